// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encodings,
// header length and byte-lane geometry of the 32-bit instruction word.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (adds the CSUM state).
package prog_loader_pkg;

  // Header carries a 16-bit little-endian word count.
  localparam int HDR_BYTES = 2;

  // Four byte lanes per 32-bit instruction word.
  localparam int LANES     = 4;
  localparam int LANE_W    = 2;
  localparam logic [LANE_W-1:0] LANE_LAST = 2'd3;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6,
    ST_CSUM  = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;
`endif

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write bus of the loader.
// master = the loader side, slave = the link / memory side.
interface prog_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] addr_bus;
  logic [31:0] data_bus;
  logic        write_en;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, addr_bus, data_bus, write_en
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, addr_bus, data_bus, write_en
  );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// Assembles four accepted bytes into a little-endian 32-bit word.
// word_valid pulses in the cycle of the fourth byte; word already holds
// that byte in [31:24], so the caller can register it on the same edge.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [LANE_W-1:0] lane_reg;
  logic [7:0]        lane_bytes [LANES-1];

  // Lane counter wraps 3 -> 0 after every fourth byte.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane_reg <= '0;
    end else if (byte_valid) begin
      lane_reg <= lane_reg + 1'b1;
    end
  end

  // One capture register per lower lane; the top lane comes straight from byte_in.
  for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_lane
    always_ff @(posedge clk) begin
      if (reset || clear) begin
        lane_bytes[gi] <= '0;
      end else if (byte_valid && lane_reg == LANE_W'(gi)) begin
        lane_bytes[gi] <= byte_in;
      end
    end
    assign word[8*gi +: 8] = lane_bytes[gi];
  end

  assign word[31:24] = byte_in;
  assign word_valid  = byte_valid && (lane_reg == LANE_LAST);

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed byte stream, writes
// little-endian 32-bit words to program memory at byte addresses 4*i,
// and holds the CPU while loading.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (trailing XOR byte check).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MAX_WORDS = 513,
  parameter int CNT_W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  prog_loader_if.master bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t ST_FINAL = ST_CSUM;
`else
  localparam state_t ST_FINAL = ST_DONE;
`endif

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  index_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       data_reg;
  logic              rx_ready;
  logic              write_en;
  logic              load_start;
  logic              xfer;
  logic              data_byte;
  logic [CNT_W-1:0]  hdr_count;
  logic [CNT_W-1:0]  index_inc;
  logic [31:0]       word;
  logic              word_valid;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_reg;
`endif

  assign xfer      = bus.rx_valid && rx_ready;
  assign data_byte = xfer && (state_reg == ST_DATA);
  assign hdr_count = CNT_W'({bus.rx_data, count_reg[7:0]});
  assign index_inc = index_reg + 1'b1;

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start),
    .byte_valid (data_byte),
    .byte_in    (bus.rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and per-state outputs; status levels decode directly from state.
  always_comb begin
    state_next = state_reg;
    rx_ready   = 1'b0;
    write_en   = 1'b0;
    cpu_hold   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    load_start = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_next = ST_LEN0;
        end
      end
      ST_LEN0: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (xfer) state_next = ST_LEN1;
      end
      ST_LEN1: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          if (hdr_count == '0)          state_next = ST_FINAL;
          else if (hdr_count > MAX_CNT) state_next = ST_ERROR;
          else                          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (word_valid) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        write_en = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        state_next = (index_inc == count_reg) ? ST_FINAL : ST_DATA;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (xfer) state_next = (bus.rx_data == csum_reg) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          load_start = 1'b1;
          state_next = ST_LEN0;
        end
      end
      ST_ERROR: begin
        cpu_hold = 1'b1;
        error    = 1'b1;
        if (start) begin
          load_start = 1'b1;
          state_next = ST_LEN0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Header count, word index and the registered write address/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      index_reg <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      if (load_start) index_reg <= '0;
      if (xfer && state_reg == ST_LEN0) count_reg <= CNT_W'(bus.rx_data);
      if (xfer && state_reg == ST_LEN1) count_reg <= hdr_count;
      // Captured on the fourth byte so the bus is valid throughout WRITE and held afterwards.
      if (word_valid) begin
        addr_reg <= {{(30-CNT_W){1'b0}}, index_reg, 2'b00};
        data_reg <= word;
      end
      if (state_reg == ST_WRITE) index_reg <= index_inc;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Running XOR over data bytes only; header bytes are excluded.
  always_ff @(posedge clk) begin
    if (reset || load_start) begin
      csum_reg <= '0;
    end else if (data_byte) begin
      csum_reg <= csum_reg ^ bus.rx_data;
    end
  end
`endif

  assign bus.rx_ready = rx_ready;
  assign bus.write_en = write_en;
  assign bus.addr_bus = addr_reg;
  assign bus.data_bus = data_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares them whenever write_en is seen.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_hold, busy, done, error;

  prog_loader_if bus_if ();

  prog_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus_if.master),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_xfer_cyc = -10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: one line per observed write, compared against the scoreboard.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus_if.rx_valid && bus_if.rx_ready) last_xfer_cyc = cyc;
      if (bus_if.write_en) begin
        $display("write addr=0x%08h data=0x%08h", bus_if.addr_bus, bus_if.data_bus);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=0x%08h/0x%08h expected=none",
                   bus_if.addr_bus, bus_if.data_bus);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", bus_if.addr_bus, e.addr);
          chk("wr_data", bus_if.data_bus, e.data);
        end
        chk("wr_rx_ready", {31'd0, bus_if.rx_ready}, 32'd0);
        chk("wr_latency", cyc - last_xfer_cyc, 32'd1);
      end
    end
  end

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offer one byte, wait (bounded) for acceptance, then idle for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    @(negedge clk);
    while (!bus_if.rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus_if.rx_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept actual=stalled expected=accepted byte=0x%02h", b);
      bus_if.rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus_if.rx_valid = 1'b0;
    $display("byte 0x%02h accepted", b);
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic wait_flag(input bit want_err);
    int t;
    t = 0;
    while (!(want_err ? error : done) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(want_err ? "wait_error" : "wait_done", {31'd0, want_err ? error : done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_rx_ready", {31'd0, bus_if.rx_ready}, 32'd0);
    chk("rst_write_en", {31'd0, bus_if.write_en}, 32'd0);
    chk("rst_status", {28'd0, cpu_hold, busy, done, error}, 32'd0);
    chk("rst_addr", bus_if.addr_bus, 32'd0);
    chk("rst_data", bus_if.data_bus, 32'd0);

    // Two-word image
    do_start();
    chk("t1_start_status", {28'd0, cpu_hold, busy, done, error}, 32'b1100);
    expect_write(32'h0, 32'h00001137);
    expect_write(32'h4, 32'h00116113);
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h37, 0); send_byte(8'h11, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h61, 0); send_byte(8'h11, 0); send_byte(8'h00, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h45, 0);
`endif
    wait_flag(1'b0);
    chk("t1_end_status", {28'd0, cpu_hold, busy, done, error}, 32'b0010);
    chk("t1_sb_empty", exp_q.size(), 32'd0);

    // Zero-length image: done right after the header
    do_start();
    chk("t2_done_cleared", {31'd0, done}, 32'd0);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    chk("t2_done_now", {28'd0, cpu_hold, busy, done, error}, 32'b0010);

    // Oversize image (514 words) rejected
    do_start();
    send_byte(8'h02, 0); send_byte(8'h02, 0);
    chk("t3_error_status", {28'd0, cpu_hold, busy, done, error}, 32'b1001);
    bus_if.rx_data  = 8'hAA;
    bus_if.rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_no_ready", {31'd0, bus_if.rx_ready}, 32'd0);
    end
    #1 bus_if.rx_valid = 1'b0;

    // One word with rx_valid toggling
    do_start();
    chk("t4_error_cleared", {31'd0, error}, 32'd0);
    expect_write(32'h0, 32'h00000013);
    send_byte(8'h01, 1); send_byte(8'h00, 1);
    send_byte(8'h13, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h13, 1);
`endif
    wait_flag(1'b0);
    chk("t4_sb_empty", exp_q.size(), 32'd0);

    // Reset mid-load, then a clean one-word image
    do_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hEF, 0); send_byte(8'hF0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_status", {28'd0, cpu_hold, busy, done, error}, 32'd0);
    chk("t5_rst_data", bus_if.data_bus, 32'd0);
    chk("t5_rst_ready", {31'd0, bus_if.rx_ready}, 32'd0);
    do_start();
    expect_write(32'h0, 32'hFFDFF0EF);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hEF, 0); send_byte(8'hF0, 0); send_byte(8'hDF, 0); send_byte(8'hFF, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h3F, 0);
`endif
    wait_flag(1'b0);
    chk("t5_sb_empty", exp_q.size(), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum mismatch: word stays written, load ends in error
    do_start();
    expect_write(32'h0, 32'h00000013);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h12, 0);
    wait_flag(1'b1);
    chk("t6_status", {28'd0, cpu_hold, busy, done, error}, 32'b1001);
    chk("t6_sb_empty", exp_q.size(), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction memory interface.
- Receives a byte stream (valid/ready) from an external link such as a UART receiver.
- Assembles little-endian 32-bit instruction words and writes them sequentially into writable program memory using byte addresses (word i at addr_bus = 4*i).
- Holds the CPU stalled while loading; releases it when the image is complete.

Parameters:
- MAX_WORDS, 513, program memory depth in words; larger images are rejected.
- CNT_W, 16, width of the header word-count field and the internal word index.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load when in IDLE, DONE or ERROR.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts a byte this cycle (transfer = rx_valid & rx_ready).
- addr_bus  output  32  program memory byte address.
- data_bus  output  32  program memory write data.
- write_en  output  1  one-cycle write strobe.
- cpu_hold  output  1  CPU stall/reset request.
- busy  output  1  load in progress.
- done  output  1  last load completed successfully (level).
- error  output  1  last load rejected (level).

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: state=IDLE; rx_ready, write_en, cpu_hold, busy, done, error = 0; addr_bus = 0; data_bus = 0; index and byte counters = 0.
- States: IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERROR (plus CSUM when the option is enabled).
- IDLE/DONE/ERROR + start → LEN0. On entry: cpu_hold=1, busy=1, done=0, error=0, index=0.
- start is ignored in any other state.
- LEN0: rx_ready=1; a transfer captures count[7:0] → LEN1.
- LEN1: rx_ready=1; a transfer captures count[15:8]. Next state:
  - count==0 → DONE (or CSUM).
  - count>MAX_WORDS → ERROR.
  - otherwise → DATA.
- DATA: rx_ready=1. Bytes fill the word little-endian: first byte → [7:0], fourth byte → [31:24]. A 2-bit byte counter wraps 3→0. On the fourth transfer → WRITE.
- WRITE: rx_ready=0 for one cycle; write_en=1, addr_bus={index,2'b00} zero-extended, data_bus=assembled word. Then index+1. If index+1==count → DONE (or CSUM), else → DATA.
- Latency: write_en is high exactly one cycle after the fourth byte's transfer cycle.
- addr_bus/data_bus hold their last value outside WRITE. write_en is never high outside WRITE.
- Bytes are never lost: rx_ready is 0 in IDLE, WRITE, DONE and ERROR.
- DONE: cpu_hold=0, busy=0, done=1.
- ERROR: cpu_hold=1, busy=0, error=1. No further writes.
- rx_valid low simply stalls; there is no timeout.
- reset asserted mid-load aborts immediately to reset values. Partial memory contents are left as-is.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - After the final data word (or after LEN1 when count==0), state CSUM accepts one byte with rx_ready=1.
  - Expected value is the XOR of all data bytes, excluding header bytes; the accumulator resets on start.
  - Match → DONE; mismatch → ERROR. Words already written stay written.
- Not defined: no CSUM state, no accumulator, no trailing byte; the image ends at the last word.

Decomposition:
- Shared include loader_defs.v, alongside instructions.v: state encodings, header length (2 bytes), byte-lane count (4).
- One natural sub-module: word_assembler (byte shift-in, 2-bit lane counter, word_valid pulse).
- prog_loader keeps the FSM, index, count and checksum logic.

Test Plan:
- Header 0x02,0x00; bytes 0x37,0x11,0x00,0x00, 0x13,0x61,0x11,0x00 → two write_en pulses: addr 0x0 data 0x00001137, then addr 0x4 data 0x00116113; then done=1, cpu_hold=0.
- Header 0x00,0x00 → no write_en; DONE two transfers after start; done=1.
- Header 0x02,0x02 (514 > 513) → ERROR; error=1, cpu_hold=1, no write_en; further rx bytes not accepted (rx_ready=0).
- One word with rx_valid toggled every other cycle → same word 0x00000013 at addr 0x0; rx_ready=0 during the WRITE cycle; no dropped bytes.
- Reset asserted after 2 of 4 data bytes, then start plus a full 1-word image 0xEF,0xF0,0xDF,0xFF → single write: addr 0x0, data 0xFFDFF0EF.
- With PROG_LOADER_CHECKSUM_EN, 1 word 0x13,0x00,0x00,0x00:
  - trailing 0x13 → done=1.
  - trailing 0x12 → error=1, with the word still written at addr 0x0.
